// File: rtl/memory_result_collector_if.sv
// Result-collector bus: upstream capture inputs, consumer handshake and status.
// master drives the collector (upstream/consumer side); slave is the collector.
interface memory_result_collector_if #(
  parameter int BW = 8,
  parameter int MW = 16
);
  localparam int CW = $clog2(MW) + 1;

  logic [BW-1:0] data_in;
  logic          busy_in;
  logic          flush;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [BW-1:0] checksum;

  modport master (
    output data_in, busy_in, flush, out_ready,
    input  out_data, out_valid, count, full, empty, overflow, checksum
  );

  modport slave (
    input  data_in, busy_in, flush, out_ready,
    output out_data, out_valid, count, full, empty, overflow, checksum
  );
endinterface

// File: rtl/memory_result_collector.sv
// Captures one result word per upstream job (busy falling edge) into a FWFT buffer.
// Optional running checksum of accepted words: define RESULT_CHECKSUM_EN.
module memory_result_collector #(
  parameter int BW = 8,
  parameter int MW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  memory_result_collector_if.slave bus
);
  localparam int AW = $clog2(MW);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(MW);

  logic [BW-1:0] mem [MW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          busy_q;
  logic          overflow;

  logic full;
  logic empty;
  logic capture;
  logic pop;
  logic accept;

  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    capture = busy_q & ~bus.busy_in;
    pop     = ~empty & bus.out_ready;
    // A pop frees the slot a same-cycle capture needs when full.
    accept  = capture & (~full | pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      busy_q <= bus.busy_in;
      if (bus.flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        if (accept && !pop)      count <= count + 1'b1;
        else if (!accept && pop) count <= count - 1'b1;
        if (capture && !accept)  overflow <= 1'b1;
      end
    end
  end

  // Storage is deliberately never cleared; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (accept && !bus.flush) mem[wr_ptr] <= bus.data_in;
  end

`ifdef RESULT_CHECKSUM_EN
  logic [BW-1:0] checksum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            checksum <= '0;
    else if (bus.flush)  checksum <= '0;
    else if (accept)     checksum <= checksum + bus.data_in;
  end

  assign bus.checksum = checksum;
`else
  assign bus.checksum = '0;
`endif

  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = ~empty;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_memory_result_collector.sv
// Randomized and directed bench for memory_result_collector against a queue-based model.
// Checksum expectations follow RESULT_CHECKSUM_EN as defined for the build.
module tb_memory_result_collector;
  localparam int BW = 8;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_result_collector_if #(.BW(BW), .MW(MW)) bus ();

  memory_result_collector #(.BW(BW), .MW(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [BW-1:0] q[$];
  bit            m_busy_q;
  bit            m_ovf;
  logic [BW-1:0] m_cks;
  logic [BW-1:0] last_pop;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] exp_cks();
`ifdef RESULT_CHECKSUM_EN
    return m_cks;
`else
    return '0;
`endif
  endfunction

  task automatic check_state();
    check("count", 32'(bus.count), 32'(q.size()));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("full", 32'(bus.full), 32'(q.size() == MW));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("checksum", 32'(bus.checksum), 32'(exp_cks()));
    if (q.size() != 0) check("out_data", 32'(bus.out_data), 32'(q[0]));
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks after the edge.
  task automatic cycle(input logic b, input logic [BW-1:0] d, input logic rdy, input logic fl);
    bit cap, pop, was_full;
    bus.busy_in   = b;
    bus.data_in   = d;
    bus.out_ready = rdy;
    bus.flush     = fl;
    cap      = m_busy_q && !b;
    pop      = (q.size() != 0) && rdy;
    was_full = (q.size() == MW);
    #1;
    if (pop) last_pop = bus.out_data;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_cks = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (!was_full || pop) begin
          q.push_back(d);
          m_cks = m_cks + d;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_busy_q = b;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic job(input logic [BW-1:0] d, input logic rdy, input logic fl);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, d, rdy, fl);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_count_async", 32'(bus.count), 32'd0);
    check("rst_valid_async", 32'(bus.out_valid), 32'd0);
    q.delete();
    m_busy_q = 1'b0;
    m_ovf    = 1'b0;
    m_cks    = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    check_state();
  endtask

  initial begin
    bus.busy_in   = 1'b1;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    rst           = 1'b0;
    m_busy_q      = 1'b0;
    m_ovf         = 1'b0;
    m_cks         = '0;
    last_pop      = '0;
    #2;
    check_state();
    @(posedge clk);
    #1 rst = 1'b1;

    // busy_in already low after reset release must not capture
    cycle(1'b0, 8'h77, 1'b0, 1'b0);
    check("no_capture_after_rst", 32'(bus.count), 32'd0);

    job(8'h05, 1'b0, 1'b0);
    check("single_count", 32'(bus.count), 32'd1);
    check("single_data", 32'(bus.out_data), 32'h05);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    for (int unsigned i = 1; i <= 17; i++) job(8'(i), 1'b0, 1'b0);
    check("ovf_full", 32'(bus.full), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int unsigned i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_order", 32'(last_pop), 32'(i));
    end
    check("drain_empty", 32'(bus.empty), 32'd1);

    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 16; i++) job(8'(8'h30 + i), 1'b0, 1'b0);
    job(8'hAA, 1'b1, 1'b0);
    check("fullpop_count", 32'(bus.count), 32'd16);
    check("fullpop_ovf", 32'(bus.overflow), 32'd0);
    for (int unsigned i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("fullpop_last", 32'(last_pop), 32'hAA);

    for (int unsigned i = 0; i < 3; i++) job(8'(8'h40 + i), 1'b0, 1'b0);
    job(8'h99, 1'b0, 1'b1);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_ovf", 32'(bus.overflow), 32'd0);
    check("flush_cks", 32'(bus.checksum), 32'd0);

    job(8'hF0, 1'b0, 1'b0);
    job(8'h20, 1'b0, 1'b0);
    job(8'h05, 1'b0, 1'b0);
`ifdef RESULT_CHECKSUM_EN
    check("cks_sum", 32'(bus.checksum), 32'h15);
`else
    check("cks_tied", 32'(bus.checksum), 32'h00);
`endif

    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 5; i++) job(8'(8'h60 + i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'd5);
    do_reset();

    for (int unsigned ph = 0; ph < 10; ph++) begin
      int unsigned pct;
      pct = $urandom_range(0, 100);
      for (int unsigned n = 0; n < 300; n++) begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset();
        end else begin
          cycle(1'($urandom), 8'($urandom), 1'($urandom_range(0, 99) < pct),
                1'($urandom_range(0, 79) == 0));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
